// File: rtl/ball_move_ctrl.sv
// Ball motion sequencer: on each divider tick, turn accelerometer tilt into a one-cell step,
// probe the world map for the candidate cell per axis, and commit only moves that miss a wall.
module ball_move_ctrl #(
  parameter int          CLK_FREQUENCY_HZ       = 100000000,
  parameter int          UPDATE_FREQUENCY_HZ    = 5,
  parameter int          CNTR_WIDTH             = 32,
  parameter bit          SIMULATE               = 1'b0,
  parameter int          SIMULATE_FREQUENCY_CNT = 5,
  parameter int          MAP_LATENCY            = 1,
  parameter logic [7:0]  WALL_CODE              = 8'd2,
  parameter logic [7:0]  HI_THRESH              = 8'd192,
  parameter logic [7:0]  LO_THRESH              = 8'd64,
  parameter logic [7:0]  X_MAX                  = 8'd127,
  parameter logic [7:0]  Y_MAX                  = 8'd127,
  parameter logic [7:0]  X_START                = 8'd0,
  parameter logic [7:0]  Y_START                = 8'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] accelX_IN,
  input  logic [7:0] accelY_IN,
  input  logic [7:0] wrld_loc_info,
  output logic [8:0] wrld_col_addr,
  output logic [8:0] wrld_row_addr,
  output logic [7:0] x_out,
  output logic [7:0] y_out,
  output logic       busy,
  output logic       move_done,
  output logic       blocked
);

  localparam logic [CNTR_WIDTH-1:0] TOP_CNT = SIMULATE ?
    CNTR_WIDTH'(SIMULATE_FREQUENCY_CNT) : CNTR_WIDTH'(CLK_FREQUENCY_HZ / UPDATE_FREQUENCY_HZ - 1);
  localparam logic [7:0] LAT = 8'(MAP_LATENCY);

  typedef enum logic [1:0] {IDLE, X_LOOK, Y_LOOK, FINISH} state_t;

  state_t                state, next;
  logic [CNTR_WIDTH-1:0] cnt;
  logic                  tick;
  logic [7:0]            dx, dy, dx_n, dy_n, wcnt;
  logic                  y_go, x_go_n, y_go_n, x_inc, x_dec, y_inc, y_dec;
  logic                  moved, blk, sample;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == TOP_CNT) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

  // Edge clamp folds into decode so a step off the map never reaches a lookup.
  always_comb begin
    x_inc  = (accelX_IN >= HI_THRESH) && (x_out != X_MAX);
    x_dec  = !(accelX_IN >= HI_THRESH) && (accelX_IN <= LO_THRESH) && (x_out != 8'd0);
    y_inc  = (accelY_IN >= HI_THRESH) && (y_out != Y_MAX);
    y_dec  = !(accelY_IN >= HI_THRESH) && (accelY_IN <= LO_THRESH) && (y_out != 8'd0);
    x_go_n = x_inc | x_dec;
    y_go_n = y_inc | y_dec;
    dx_n   = x_inc ? 8'd1 : 8'hFF;
    dy_n   = y_inc ? 8'd1 : 8'hFF;
  end

  assign sample = (wcnt == LAT);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (tick) next = x_go_n ? X_LOOK : (y_go_n ? Y_LOOK : IDLE);
      X_LOOK:  if (sample) next = y_go ? Y_LOOK : FINISH;
      Y_LOOK:  if (sample) next = FINISH;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_out <= X_START;
      y_out <= Y_START;
      dx    <= '0;
      dy    <= '0;
      y_go  <= 1'b0;
      wcnt  <= '0;
      moved <= 1'b0;
      blk   <= 1'b0;
    end else begin
      // wcnt measures cycles since the current lookup address became stable
      if (state != next)                           wcnt <= '0;
      else if (state == X_LOOK || state == Y_LOOK) wcnt <= wcnt + 1'b1;
      case (state)
        IDLE: if (tick) begin
          dx    <= dx_n;
          dy    <= dy_n;
          y_go  <= y_go_n;
          moved <= 1'b0;
          blk   <= 1'b0;
        end
        X_LOOK: if (sample) begin
          if (wrld_loc_info != WALL_CODE) begin
            x_out <= x_out + dx;
            moved <= 1'b1;
          end else blk <= 1'b1;
        end
        Y_LOOK: if (sample) begin
          if (wrld_loc_info != WALL_CODE) begin
            y_out <= y_out + dy;
            moved <= 1'b1;
          end else blk <= 1'b1;
        end
        default: begin
          moved <= 1'b0;
          blk   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wrld_col_addr = {1'b0, (state == X_LOOK) ? x_out + dx : x_out};
    wrld_row_addr = {1'b0, (state == Y_LOOK) ? y_out + dy : y_out};
    busy          = (state != IDLE);
    move_done     = (state == FINISH) && moved;
    blocked       = (state == FINISH) && blk;
  end

endmodule
